// File: rtl/ddr2_rd_arbiter.sv
// Purpose : round-robin arbiter sharing the DDR2 manager's single read port among NUM_REQ clients.
// Latency : req_valid -> rd_mem_req 1 cycle; rd_mem_grant -> req_grant 1 cycle; data demux is combinational.
// Backpr. : clients hold req_valid until req_grant; a watchdog aborts hung transfers and sets err[0].
// Ports   : req_* client side (packed per client), rd_mem_* / rd_data* manager side,
//           busy/owner/err status, err_clr clears the sticky error flags.
module ddr2_rd_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int BEATS_PER_XFR = 2,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic                    clk0,
    input  logic                    rst0_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [25*NUM_REQ-1:0]   req_addr,
    input  logic [10*NUM_REQ-1:0]   req_len,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [NUM_REQ-1:0]      req_data_valid,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [31:0]             req_data,
    output logic                    rd_mem_req,
    output logic [24:0]             rd_mem_addr,
    output logic [9:0]              rd_xfr_len,
    input  logic                    rd_mem_grant,
    input  logic [31:0]             rd_data,
    input  logic                    rd_data_valid,
    input  logic                    err_clr,
    output logic                    busy,
    output logic [1:0]              owner,
    output logic [1:0]              err
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic                rd_mem_req_q, rd_mem_req_d;
    logic [24:0]         addr_q, addr_d;
    logic [9:0]          len_q, len_d;
    logic [NUM_REQ-1:0]  req_grant_q, req_grant_d;
    logic [NUM_REQ-1:0]  req_done_q, req_done_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          err_q, err_d;
    logic [11:0]         beat_cnt_q, beat_cnt_d;
    logic [15:0]         wd_q, wd_d;

    logic                found;
    int                  pick;
    int                  idx;
    logic [1:0]          owner_inc;
    logic [NUM_REQ-1:0]  owner_oh;
    logic [11:0]         beat_nxt;
    logic [15:0]         exp_beats;
    logic                wd_hit;
    logic                last_beat;
    logic                timeout_evt;
    logic                stray_evt;

    assign owner_oh  = NUM_REQ'(1) << owner_q;
    assign owner_inc = (owner_q == 2'(NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;
    assign beat_nxt  = beat_cnt_q + 12'd1;
    // Length 0 encodes the maximum transfer of 1024 units.
    assign exp_beats = ((len_q == 10'd0) ? 16'd1024 : {6'd0, len_q}) * 16'(BEATS_PER_XFR);
    // Hit on the cycle whose edge brings the count to TIMEOUT_CYC.
    assign wd_hit    = (wd_q == 16'(TIMEOUT_CYC - 1));
    assign last_beat = (state_q == XFER) && rd_data_valid && ({4'd0, beat_nxt} == exp_beats);
    assign timeout_evt = wd_hit && (((state_q == REQ) && !rd_mem_grant) ||
                                    ((state_q == XFER) && !last_beat));
    assign stray_evt = rd_data_valid && (state_q != XFER);

    // Round-robin search starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = 0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_mem_req_d = rd_mem_req_q;
        addr_d       = addr_q;
        len_d        = len_q;
        req_grant_d  = '0;
        req_done_d   = '0;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        wd_d         = wd_q;
        // A set event in the same cycle as err_clr wins.
        err_d        = (err_clr ? 2'b00 : err_q) | {stray_evt, timeout_evt};

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d      = 2'(pick);
                    addr_d       = req_addr[pick*25 +: 25];
                    len_d        = req_len[pick*10 +: 10];
                    rd_mem_req_d = 1'b1;
                    wd_d         = 16'd0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                wd_d = wd_q + 16'd1;
                if (rd_mem_grant) begin
                    rd_mem_req_d = 1'b0;
                    req_grant_d  = owner_oh;
                    rr_ptr_d     = owner_inc;
                    beat_cnt_d   = 12'd0;
                    state_d      = XFER;
                end else if (timeout_evt) begin
                    // Advance past the hung owner so the others are not starved.
                    rd_mem_req_d = 1'b0;
                    rr_ptr_d     = owner_inc;
                    req_done_d   = owner_oh;
                    state_d      = DONE;
                end
            end
            XFER: begin
                wd_d = wd_q + 16'd1;
                if (rd_data_valid) begin
                    beat_cnt_d = beat_nxt;
                end
                if (last_beat || timeout_evt) begin
                    req_done_d = owner_oh;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            state_q      <= IDLE;
            rd_mem_req_q <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            req_grant_q  <= '0;
            req_done_q   <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            err_q        <= '0;
            beat_cnt_q   <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            rd_mem_req_q <= rd_mem_req_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            req_grant_q  <= req_grant_d;
            req_done_q   <= req_done_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
            beat_cnt_q   <= beat_cnt_d;
            wd_q         <= wd_d;
        end
    end

    // Beats are only forwarded while a transfer is open; anything else is stray.
    assign req_data_valid = (state_q == XFER && rd_data_valid) ? owner_oh : '0;
    assign req_data       = rd_data;
    assign rd_mem_req     = rd_mem_req_q;
    assign rd_mem_addr    = addr_q;
    assign rd_xfr_len     = len_q;
    assign req_grant      = req_grant_q;
    assign req_done       = req_done_q;
    assign busy           = (state_q != IDLE);
    assign owner          = owner_q;
    assign err            = err_q;

endmodule

// File: tb/tb_ddr2_rd_arbiter.sv
// Purpose : directed bench for ddr2_rd_arbiter acting as both clients and the DDR2 manager.
// Latency : checks registered outputs 1ns after the edge, combinational demux 1ns after driving.
// Backpr. : the bench grants and streams beats itself; every wait is bounded.
module tb_ddr2_rd_arbiter;
    localparam int NR  = 2;
    localparam int BPX = 2;
    // Long enough that a 2048-beat transfer completes before the watchdog fires.
    localparam int TO  = 4096;

    logic              clk0 = 1'b0;
    logic              rst0_n;
    logic [NR-1:0]     req_valid;
    logic [25*NR-1:0]  req_addr;
    logic [10*NR-1:0]  req_len;
    logic [NR-1:0]     req_grant, req_data_valid, req_done;
    logic [31:0]       req_data;
    logic              rd_mem_req;
    logic [24:0]       rd_mem_addr;
    logic [9:0]        rd_xfr_len;
    logic              rd_mem_grant;
    logic [31:0]       rd_data;
    logic              rd_data_valid;
    logic              err_clr;
    logic              busy;
    logic [1:0]        owner;
    logic [1:0]        err;

    typedef struct { int owner; logic [24:0] addr; logic [9:0] len; } exp_req_t;
    typedef struct { logic [NR-1:0] dv; logic [31:0] dat; } exp_beat_t;
    exp_req_t  exp_q[$];
    exp_beat_t beat_q[$];

    int n_pass  = 0;
    int n_total = 0;

    ddr2_rd_arbiter #(.NUM_REQ(NR), .BEATS_PER_XFR(BPX), .TIMEOUT_CYC(TO)) dut (
        .clk0(clk0), .rst0_n(rst0_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_grant(req_grant), .req_data_valid(req_data_valid),
        .req_done(req_done), .req_data(req_data), .rd_mem_req(rd_mem_req),
        .rd_mem_addr(rd_mem_addr), .rd_xfr_len(rd_xfr_len), .rd_mem_grant(rd_mem_grant),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .err_clr(err_clr),
        .busy(busy), .owner(owner), .err(err)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic set_client(input int i, input logic [24:0] a, input logic [9:0] l);
        req_addr[25*i +: 25] = a;
        req_len[10*i +: 10]  = l;
    endtask

    task automatic do_reset();
        rst0_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
        rd_mem_grant = 1'b0; rd_data = '0; rd_data_valid = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        rst0_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_req"}, rd_mem_req, 0);
        chk({tag, "_addr"}, rd_mem_addr, 0);
        chk({tag, "_len"}, rd_xfr_len, 0);
        chk({tag, "_grant"}, req_grant, 0);
        chk({tag, "_done"}, req_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Serves the next expected request as the manager: grant, stream beats, check completion.
    task automatic run_xfer(input bit keep);
        exp_req_t  e;
        exp_beat_t eb;
        int        nb;
        e = exp_q.pop_front();
        for (int i = 0; i < 20 && !rd_mem_req; i++) tick();
        chk("mem_req_seen", rd_mem_req, 1);
        chk("owner", owner, e.owner);
        chk("mem_addr", rd_mem_addr, e.addr);
        chk("xfr_len", rd_xfr_len, e.len);
        rd_mem_grant = 1'b1;
        tick();
        rd_mem_grant = 1'b0;
        chk("grant_pulse", req_grant, 1 << e.owner);
        chk("mem_req_drop", rd_mem_req, 0);
        if (!keep) req_valid[e.owner] = 1'b0;
        tick();
        chk("grant_one_cycle", req_grant, 0);
        nb = ((e.len == 10'd0) ? 1024 : int'(e.len)) * BPX;
        for (int b = 0; b < nb; b++) begin
            rd_data_valid = 1'b1;
            rd_data       = $urandom;
            beat_q.push_back('{dv: NR'(1 << e.owner), dat: rd_data});
            #1;
            eb = beat_q.pop_front();
            chk("beat_dv", req_data_valid, eb.dv);
            chk("beat_dat", req_data, eb.dat);
            tick();
            if (b == nb - 2) begin
                chk("no_early_done", req_done, 0);
                chk("busy_before_last", busy, 1);
            end
        end
        rd_data_valid = 1'b0;
        chk("done_pulse", req_done, 1 << e.owner);
        tick();
        chk("done_one_cycle", req_done, 0);
        chk("idle_gap_busy", busy, 0);
        chk("idle_gap_mem_req", rd_mem_req, 0);
    endtask

    initial begin
        do_reset();
        chk_reset_vals("reset");
        chk("reset_dv", req_data_valid, 0);

        // Single client 0, len 4 -> 8 beats.
        set_client(0, 25'h0001000, 10'd4);
        exp_q.push_back('{0, 25'h0001000, 10'd4});
        req_valid = 2'b01;
        chk("req_not_yet", rd_mem_req, 0);
        tick();
        chk("req_latency", rd_mem_req, 1);
        chk("busy_in_req", busy, 1);
        run_xfer(1'b0);

        // Two continuous requesters, len 1: strict alternation starting at client 0.
        do_reset();
        set_client(0, 25'h0000100, 10'd1);
        set_client(1, 25'h1ABCDEF, 10'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back('{i % 2, (i % 2) ? 25'h1ABCDEF : 25'h0000100, 10'd1});
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) run_xfer(1'b1);
        req_valid = 2'b00;

        // len 0 from client 1 needs 2048 beats.
        do_reset();
        set_client(1, 25'h0FF0000, 10'd0);
        exp_q.push_back('{1, 25'h0FF0000, 10'd0});
        req_valid = 2'b10;
        run_xfer(1'b0);

        // Watchdog: never grant.
        do_reset();
        set_client(0, 25'h0000AAA, 10'd2);
        set_client(1, 25'h0000BBB, 10'd2);
        req_valid = 2'b11;
        tick();
        chk("wd_req_rise", rd_mem_req, 1);
        repeat (TO - 1) tick();
        chk("wd_req_held", rd_mem_req, 1);
        tick();
        chk("wd_req_drop", rd_mem_req, 0);
        chk("wd_err", err, 2'b01);
        chk("wd_done", req_done, 2'b01);
        tick();
        chk("wd_done_one_cycle", req_done, 0);
        tick();
        chk("wd_next_req", rd_mem_req, 1);
        chk("wd_next_owner", owner, 1);
        chk("wd_next_addr", rd_mem_addr, 25'h0000BBB);
        req_valid = 2'b00;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_err_clr", err, 2'b00);

        // Stray beats in IDLE.
        do_reset();
        rd_data_valid = 1'b1;
        rd_data = 32'hDEADBEEF;
        #1;
        chk("stray_no_dv", req_data_valid, 0);
        tick();
        rd_data_valid = 1'b0;
        chk("stray_err", err, 2'b10);
        rd_data_valid = 1'b1;
        err_clr = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        err_clr = 1'b1;
        chk("stray_set_wins", err, 2'b10);
        tick();
        err_clr = 1'b0;
        chk("stray_clr", err, 2'b00);

        // Reset during XFER.
        do_reset();
        set_client(1, 25'h0123456, 10'd4);
        req_valid = 2'b10;
        tick();
        chk("rst_owner_pre", owner, 1);
        rd_mem_grant = 1'b1;
        tick();
        rd_mem_grant = 1'b0;
        req_valid = 2'b00;
        chk("rst_grant", req_grant, 2'b10);
        rd_data_valid = 1'b1;
        repeat (3) tick();
        rd_data_valid = 1'b0;
        chk("rst_busy_pre", busy, 1);
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
        chk_reset_vals("midrst");
        rd_data_valid = 1'b1;
        #1;
        chk("midrst_no_dv", req_data_valid, 0);
        tick();
        tick();
        rd_data_valid = 1'b0;
        chk("midrst_stray_err", err, 2'b10);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_done", req_done, 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
